// File: rtl/frame_buffer_reader.sv
// Double-buffered frame reader: maps display timing onto a 2x-scaled image in BRAM,
// aligns timing with the 2-cycle BRAM read, and swaps buffers once per completed frame.
module frame_buffer_reader #(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int H_START     = 320,
  parameter int V_START     = 120,
  parameter int FRAME_WORDS = 76800,
  parameter int V_SWAP      = 720
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        active_in,
  input  logic        frame_done_in,
  input  logic [6:0]  bram_data_in,
  output logic [17:0] bram_addr_out,
  output logic        buf_sel_out,
  output logic        swap_ack_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic [6:0]  pixel_out,
  output logic        data_valid_out
);

  localparam logic [11:0] H_LO     = 12'(H_START);
  localparam logic [11:0] H_HI     = 12'(H_START + 2 * IMG_W);
  localparam logic [10:0] V_LO     = 11'(V_START);
  localparam logic [10:0] V_HI     = 11'(V_START + 2 * IMG_H);
  localparam logic [10:0] H_OFS    = 11'(H_START);
  localparam logic [9:0]  V_OFS    = 10'(V_START);
  localparam logic [9:0]  V_SWAP_L = 10'(V_SWAP);
  localparam logic [17:0] IMG_W_L  = 18'(IMG_W);
  localparam logic [17:0] FW_L     = 18'(FRAME_WORDS);

  typedef enum logic [0:0] {
    SCAN    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  swap_state_t state_r, state_next_s;
  logic        swap_s;
  logic        buf_sel_r;
  logic        swap_ack_r;
  logic        in_region_s;
  logic        swap_point_s;
  logic [10:0] h_off_s;
  logic [9:0]  v_off_s;
  logic [9:0]  x_s;
  logic [8:0]  y_s;
  logic [17:0] base_s;
  logic [17:0] pix_off_s;
  logic [17:0] addr_r;
  logic [10:0] h_d_r   [0:2];
  logic [9:0]  v_d_r   [0:2];
  logic [2:0]  act_d_r;
  logic [2:0]  reg_d_r;

  // Region test and 2x-downscaled image coordinates
  always_comb begin
    in_region_s = active_in
                  && ({1'b0, hcount_in} >= H_LO) && ({1'b0, hcount_in} < H_HI)
                  && ({1'b0, vcount_in} >= V_LO) && ({1'b0, vcount_in} < V_HI);
    h_off_s      = hcount_in - H_OFS;
    v_off_s      = vcount_in - V_OFS;
    x_s          = 10'(h_off_s >> 1'b1);
    y_s          = 9'(v_off_s >> 1'b1);
    base_s       = buf_sel_r ? FW_L : 18'd0;
    pix_off_s    = (18'(y_s) * IMG_W_L) + 18'(x_s);
    swap_point_s = (vcount_in == V_SWAP_L) && (hcount_in == 11'd0);
  end

  // Swap FSM next state; extra frame_done pulses while pending fall through
  always_comb begin
    state_next_s = state_r;
    swap_s       = 1'b0;
    case (state_r)
      SCAN: begin
        if (frame_done_in) begin
          state_next_s = PENDING;
        end else begin
          state_next_s = SCAN;
        end
      end
      PENDING: begin
        if (swap_point_s) begin
          state_next_s = SCAN;
          swap_s       = 1'b1;
        end else begin
          state_next_s = PENDING;
        end
      end
      default: begin
        state_next_s = SCAN;
      end
    endcase
  end

  // Swap FSM state, buffer select and acknowledge pulse
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r    <= SCAN;
      buf_sel_r  <= 1'b0;
      swap_ack_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      buf_sel_r  <= buf_sel_r ^ swap_s;
      swap_ack_r <= swap_s;
    end
  end

  // Address register; the buffer base is captured with the address so a swap never splits a pixel
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      addr_r <= 18'd0;
    end else if (in_region_s) begin
      addr_r <= base_s + pix_off_s;
    end else begin
      addr_r <= base_s;
    end
  end

  // Three-stage delay lines matching address register plus BRAM latency
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 3; i++) begin
        h_d_r[i] <= 11'd0;
        v_d_r[i] <= 10'd0;
      end
      act_d_r <= 3'd0;
      reg_d_r <= 3'd0;
    end else begin
      h_d_r[0] <= hcount_in;
      v_d_r[0] <= vcount_in;
      for (int i = 1; i < 3; i++) begin
        h_d_r[i] <= h_d_r[i-1];
        v_d_r[i] <= v_d_r[i-1];
      end
      act_d_r <= {act_d_r[1:0], active_in};
      reg_d_r <= {reg_d_r[1:0], in_region_s};
    end
  end

  // BRAM data arrives already registered, so gating it here keeps the 3-cycle latency
  always_comb begin
    if (reg_d_r[2]) begin
      pixel_out = bram_data_in;
    end else begin
      pixel_out = 7'd0;
    end
  end

  assign bram_addr_out  = addr_r;
  assign buf_sel_out    = buf_sel_r;
  assign swap_ack_out   = swap_ack_r;
  assign hcount_out     = h_d_r[2];
  assign vcount_out     = v_d_r[2];
  assign data_valid_out = act_d_r[2];

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader with a 2-cycle-latency BRAM model.
module tb_frame_buffer_reader;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        active_in;
  logic        frame_done_in;
  logic [6:0]  bram_data_in;
  logic [17:0] bram_addr_out;
  logic        buf_sel_out;
  logic        swap_ack_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [6:0]  pixel_out;
  logic        data_valid_out;

  int checks = 0;
  int errors = 0;

  logic [6:0] q1_r = 7'd0;
  logic [6:0] q2_r = 7'd0;

  frame_buffer_reader dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .active_in(active_in), .frame_done_in(frame_done_in), .bram_data_in(bram_data_in),
    .bram_addr_out(bram_addr_out), .buf_sel_out(buf_sel_out), .swap_ack_out(swap_ack_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .pixel_out(pixel_out),
    .data_valid_out(data_valid_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [6:0] mem_word(input logic [17:0] a);
    return a[6:0] ^ 7'h2A;
  endfunction

  // BRAM model: two register stages of read latency
  always @(posedge clk_in) begin
    q1_r <= mem_word(bram_addr_out);
    q2_r <= q1_r;
  end
  assign bram_data_in = q2_r;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic a, input logic fd);
    hcount_in     = h;
    vcount_in     = v;
    active_in     = a;
    frame_done_in = fd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in = 1'b0;
    drive(11'd320, 10'd120, 1'b1, 1'b1);
    step(); step(); step();
    chk("rst_addr",  32'(bram_addr_out), 32'd0);
    chk("rst_bsel",  32'(buf_sel_out),   32'd0);
    chk("rst_ack",   32'(swap_ack_out),  32'd0);
    chk("rst_hout",  32'(hcount_out),    32'd0);
    chk("rst_vout",  32'(vcount_out),    32'd0);
    chk("rst_pix",   32'(pixel_out),     32'd0);
    chk("rst_valid", 32'(data_valid_out), 32'd0);

    // First image pixel, buffer 0
    rst_in = 1'b1;
    drive(11'd320, 10'd120, 1'b1, 1'b0);
    step();
    chk("p0_addr", 32'(bram_addr_out), 32'd0);
    drive(11'd0, 10'd0, 1'b0, 1'b0);
    step();
    chk("p0_valid_early", 32'(data_valid_out), 32'd0);
    step();
    chk("p0_pix",   32'(pixel_out),      32'(mem_word(18'd0)));
    chk("p0_hout",  32'(hcount_out),     32'd320);
    chk("p0_vout",  32'(vcount_out),     32'd120);
    chk("p0_valid", 32'(data_valid_out), 32'd1);
    step();
    chk("p0_valid_late", 32'(data_valid_out), 32'd0);

    // Interior pixel: x=90, y=90
    drive(11'd500, 10'd300, 1'b1, 1'b0);
    step();
    chk("mid_addr", 32'(bram_addr_out), 32'd28890);
    drive(11'd0, 10'd0, 1'b0, 1'b0);
    step(); step();
    chk("mid_pix", 32'(pixel_out), 32'(mem_word(18'd28890)));

    // Active border left of the image
    drive(11'd319, 10'd200, 1'b1, 1'b0);
    step();
    chk("bord_addr", 32'(bram_addr_out), 32'd0);
    drive(11'd0, 10'd0, 1'b0, 1'b0);
    step(); step();
    chk("bord_pix",   32'(pixel_out),      32'd0);
    chk("bord_valid", 32'(data_valid_out), 32'd1);
    chk("bord_hout",  32'(hcount_out),     32'd319);

    // Inside coordinates but inactive
    drive(11'd400, 10'd200, 1'b0, 1'b0);
    step();
    chk("inact_addr", 32'(bram_addr_out), 32'd0);
    drive(11'd960, 10'd300, 1'b1, 1'b0);
    step();
    chk("right_edge_addr", 32'(bram_addr_out), 32'd0);
    step();
    chk("inact_valid", 32'(data_valid_out), 32'd0);
    chk("inact_pix",   32'(pixel_out),      32'd0);
    step();
    chk("right_edge_pix", 32'(pixel_out), 32'd0);

    // Single frame_done, swap at line 720
    drive(11'd5, 10'd300, 1'b0, 1'b1);
    step();
    drive(11'd5, 10'd500, 1'b0, 1'b0);
    step(); step();
    chk("sw1_bsel_pre", 32'(buf_sel_out),  32'd0);
    chk("sw1_ack_pre",  32'(swap_ack_out), 32'd0);
    drive(11'd0, 10'd720, 1'b0, 1'b0);
    step();
    chk("sw1_bsel", 32'(buf_sel_out),  32'd1);
    chk("sw1_ack",  32'(swap_ack_out), 32'd1);
    drive(11'd1, 10'd720, 1'b0, 1'b0);
    step();
    chk("sw1_ack_post",  32'(swap_ack_out), 32'd0);
    chk("sw1_bsel_post", 32'(buf_sel_out),  32'd1);

    // Last pixel of buffer 1, and 2x horizontal scaling
    drive(11'd959, 10'd599, 1'b1, 1'b0);
    step();
    chk("last_addr", 32'(bram_addr_out), 32'd153599);
    drive(11'd958, 10'd599, 1'b1, 1'b0);
    step();
    chk("last_addr_958", 32'(bram_addr_out), 32'd153599);
    drive(11'd0, 10'd0, 1'b0, 1'b0);
    step();
    chk("last_pix",  32'(pixel_out),  32'(mem_word(18'd153599)));
    chk("last_hout", 32'(hcount_out), 32'd959);
    step();
    chk("buf1_base_addr", 32'(bram_addr_out), 32'd76800);

    // Two frame_done pulses -> one toggle, then no toggle without a new pulse
    drive(11'd5, 10'd100, 1'b0, 1'b1);
    step();
    drive(11'd5, 10'd200, 1'b0, 1'b0);
    step();
    drive(11'd5, 10'd400, 1'b0, 1'b1);
    step();
    drive(11'd0, 10'd720, 1'b0, 1'b0);
    step();
    chk("sw2_bsel", 32'(buf_sel_out),  32'd0);
    chk("sw2_ack",  32'(swap_ack_out), 32'd1);
    drive(11'd1, 10'd720, 1'b0, 1'b0);
    step();
    chk("sw2_ack_post", 32'(swap_ack_out), 32'd0);
    drive(11'd0, 10'd720, 1'b0, 1'b0);
    step();
    chk("sw2_noswap_bsel", 32'(buf_sel_out),  32'd0);
    chk("sw2_noswap_ack",  32'(swap_ack_out), 32'd0);

    // frame_done on a swap point while scanning: swap only at the next one
    drive(11'd0, 10'd720, 1'b0, 1'b1);
    step();
    chk("sw3_same_bsel", 32'(buf_sel_out),  32'd0);
    chk("sw3_same_ack",  32'(swap_ack_out), 32'd0);
    drive(11'd1, 10'd720, 1'b0, 1'b0);
    step();
    drive(11'd0, 10'd720, 1'b0, 1'b0);
    step();
    chk("sw3_bsel", 32'(buf_sel_out),  32'd1);
    chk("sw3_ack",  32'(swap_ack_out), 32'd1);

    // Reset while pending discards the swap; valid resumes after 3 cycles
    drive(11'd5, 10'd300, 1'b0, 1'b1);
    step();
    drive(11'd320, 10'd120, 1'b1, 1'b0);
    step();
    rst_in = 1'b0;
    step(); step();
    chk("rst2_bsel", 32'(buf_sel_out), 32'd0);
    rst_in = 1'b1;
    step();
    chk("rst2_valid1", 32'(data_valid_out), 32'd0);
    chk("rst2_pix1",   32'(pixel_out),      32'd0);
    step();
    chk("rst2_valid2", 32'(data_valid_out), 32'd0);
    step();
    chk("rst2_valid3", 32'(data_valid_out), 32'd1);
    chk("rst2_pix3",   32'(pixel_out),      32'(mem_word(18'd0)));
    drive(11'd0, 10'd720, 1'b0, 1'b0);
    step();
    chk("rst2_sw_bsel", 32'(buf_sel_out),  32'd0);
    chk("rst2_sw_ack",  32'(swap_ack_out), 32'd0);
    drive(11'd1, 10'd720, 1'b0, 1'b0);
    step();
    chk("rst2_sw_ack_post", 32'(swap_ack_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_reader.md
FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  IMG_W, 320, stored image width in pixels.
  IMG_H, 240, stored image height in lines.
  H_START, 320, first display column of the 2x-scaled image.
  V_START, 120, first display line of the 2x-scaled image.
  FRAME_WORDS, 76800, words per buffer (IMG_W*IMG_H).
  V_SWAP, 720, display line on which a pending buffer swap occurs.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk_in  input  1  single clock for all logic.
  rst_in  input  1  synchronous active-low reset.
  hcount_in  input  11  display column from the timing generator.
  vcount_in  input  10  display line from the timing generator.
  active_in  input  1  display active-region flag.
  frame_done_in  input  1  one-cycle pulse: the writer has completed a frame.
  bram_data_in  input  7  BRAM read data, 2-cycle read latency.
  bram_addr_out  output  18  BRAM read address, registered.
  buf_sel_out  output  1  buffer being displayed; the writer uses the other one.
  swap_ack_out  output  1  one-cycle pulse when buf_sel_out toggles.
  hcount_out  output  11  hcount_in delayed to align with pixel_out.
  vcount_out  output  10  vcount_in delayed to align with pixel_out.
  pixel_out  output  7  display pixel.
  data_valid_out  output  1  active_in delayed to align with pixel_out.

Function
REQ-003 The in-region flag SHALL be active_in AND H_START <= hcount_in < H_START+2*IMG_W AND V_START <= vcount_in < V_START+2*IMG_H.
REQ-004 Coordinates SHALL be x=(hcount_in-H_START)>>1 and y=(vcount_in-V_START)>>1, both computed unsigned.
REQ-005 bram_addr_out SHALL register buf_sel_out*FRAME_WORDS + y*IMG_W + x when in-region, else buf_sel_out*FRAME_WORDS, one cycle after the inputs.
REQ-006 Total latency SHALL be exactly 3 cycles (1 address register + 2 BRAM): the outputs at cycle N+3 SHALL correspond to the inputs at cycle N.
REQ-007 hcount_out, vcount_out, data_valid_out and the in-region flag SHALL each pass through a 3-stage delay line.
REQ-008 pixel_out SHALL equal bram_data_in when the delayed in-region flag is 1, and 0 otherwise (border, including the active border).
REQ-009 The swap FSM SHALL have two states: SCAN and PENDING.
REQ-010 SCAN: frame_done_in=1 SHALL move the FSM to PENDING; otherwise it SHALL stay in SCAN.
REQ-011 PENDING: on the cycle where vcount_in==V_SWAP and hcount_in==0, the block SHALL toggle buf_sel_out, pulse swap_ack_out for 1 cycle, and return to SCAN.
REQ-012 frame_done_in while in PENDING SHALL be ignored; multiple pulses before a swap point SHALL yield exactly one toggle.
REQ-013 frame_done_in arriving in the same cycle as a swap point while in SCAN SHALL only enter PENDING; the swap SHALL occur at the next swap point.
REQ-014 buf_sel_out SHALL change only at a swap point, never in the active region; addresses already in the pipeline SHALL keep their originally registered buffer.
REQ-015 The address arithmetic SHALL be performed at 18 bits without overflow; the maximum address is 2*FRAME_WORDS-1 = 153599.

Reset
REQ-016 While rst_in=0 at a clock edge, all outputs, all delay-line stages and buf_sel_out SHALL become 0, and the FSM SHALL enter SCAN.
REQ-017 Reset asserted mid-frame or while in PENDING SHALL discard the pending swap; outputs SHALL resume 3 cycles after release with no stale valid data.

Verification
REQ-018 hcount_in=320, vcount_in=120, active_in=1, buf_sel 0 -> bram_addr_out=0 at +1 cycle; pixel_out = the BRAM word, with hcount_out=320 and vcount_out=120, at +3 cycles.
REQ-019 hcount_in=959, vcount_in=599, buf_sel 1 -> bram_addr_out=153599; hcount_in=958 -> same address as 959 (2x scale).
REQ-020 hcount_in=319, vcount_in=200, active_in=1 -> pixel_out=0 and data_valid_out=1 at +3 cycles; active_in=0 -> data_valid_out=0.
REQ-021 frame_done_in pulse at vcount_in=300 -> buf_sel_out toggles 0->1 and swap_ack_out=1 for exactly 1 cycle at vcount_in=720, hcount_in=0.
REQ-022 frame_done_in pulses at lines 100 and 400 of the same frame -> exactly one toggle at line 720.
REQ-023 frame_done_in pulse, then rst_in=0 for 2 cycles before line 720 -> buf_sel_out=0 and no swap_ack_out at line 720.
